// File: rtl/cnt_disp_pkg.sv
// Shared types, 7-segment glyph constants and small helpers for the
// counter display slice (cnt_seg_disp and its BCD converter).
package cnt_disp_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} conv_state_e;

  // Segment order {g,f,e,d,c,b,a}, active-low: a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [2:0] MODE_TM_DN = 3'd0;
  localparam logic [2:0] MODE_TM_UP = 3'd1;
  localparam logic [2:0] MODE_EV_DN = 3'd4;
  localparam logic [2:0] MODE_EV_UP = 3'd5;

  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
  } glyph_t;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Digit-3 glyph: direction letter, decimal point lit for event modes.
  function automatic glyph_t mode_glyph(input logic [2:0] m);
    case (m)
      MODE_TM_DN: return '{seg: SEG_D,    dp: 1'b1};
      MODE_TM_UP: return '{seg: SEG_U,    dp: 1'b1};
      MODE_EV_DN: return '{seg: SEG_D,    dp: 1'b0};
      MODE_EV_UP: return '{seg: SEG_U,    dp: 1'b0};
      default:    return '{seg: SEG_DASH, dp: 1'b1};
    endcase
  endfunction

  // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [11:0] dd_adjust(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/cnt_seg_disp_bin2bcd8.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits in
// LOAD + 8 SHIFT + DONE cycles after a start in IDLE.
module bin2bcd8
  import cnt_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [7:0]  value_i,
  output logic [11:0] bcd_o,
  output logic        busy_o,
  output logic        load_o,
  output logic        done_o
);

  conv_state_e state_q, state_d;
  logic [7:0]  sh_q;
  logic [11:0] bcd_q;
  logic [2:0]  iter_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: next-state defaults to the current state before the case so no
  // path through the block leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (iter_q == 3'd7) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          sh_q   <= value_i;
          bcd_q  <= '0;
          iter_q <= '0;
        end
        SHIFT: begin
          {bcd_q, sh_q} <= {dd_adjust(bcd_q), sh_q} << 1;
          iter_q        <= iter_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q != IDLE);
    load_o = (state_q == LOAD);
    done_o = (state_q == DONE);
    bcd_o  = bcd_q;
  end

endmodule

// File: rtl/cnt_seg_disp.sv
// 4-digit multiplexed common-anode display of an 8-bit count plus mode glyph.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
module cnt_seg_disp
  import cnt_disp_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] count,
  input  logic [2:0] mode,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       busy
);

  logic        conv_busy, conv_load, conv_done, start, mismatch;
  logic [11:0] conv_bcd;
  logic [7:0]  last_conv_q;
  logic        pending_q;
  logic [11:0] disp_q;
  logic [SCAN_W-1:0] presc_q;
  logic [1:0]  idx_q;
  logic        tick;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [3:0]  ones, tens, hund;
  logic        blank_tens, blank_hund;
  glyph_t      glyph;

  // pending_q remembers a change seen mid-conversion even if count later
  // returns to the latched value, so the converter always re-arms.
  assign mismatch = (count != last_conv_q);
  assign start    = !conv_busy && (mismatch || pending_q);

  bin2bcd8 u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .value_i (count),
    .bcd_o   (conv_bcd),
    .busy_o  (conv_busy),
    .load_o  (conv_load),
    .done_o  (conv_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_conv_q <= '0;
      pending_q   <= 1'b0;
      disp_q      <= '0;
    end else begin
      if (conv_load) last_conv_q <= count;
      pending_q <= (conv_busy && !conv_load) ? (pending_q | mismatch) : 1'b0;
      // Whole result copied in one edge: the display never shows scratch.
      if (conv_done) disp_q <= conv_bcd;
    end
  end

  assign tick = (presc_q == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + SCAN_W'(1);
      if (tick) idx_q <= idx_q + 2'd1;
    end
  end

  assign {hund, tens, ones} = disp_q;
  assign glyph = mode_glyph(mode);

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_hund = (hund == 4'd0);
  assign blank_tens = blank_hund && (tens == 4'd0);
`else
  assign blank_hund = 1'b0;
  assign blank_tens = 1'b0;
`endif

  always_comb begin
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    case (idx_q)
      2'd0:    seg_d = seg_digit(ones);
      2'd1:    seg_d = blank_tens ? SEG_BLANK : seg_digit(tens);
      2'd2:    seg_d = blank_hund ? SEG_BLANK : seg_digit(hund);
      default: begin
        seg_d = glyph.seg;
        dp_d  = glyph.dp;
      end
    endcase
  end

  assign an_d = ~(4'b0001 << idx_q);

  // Pin-facing outputs are registered; reset leaves every digit dark.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= 4'b1111;
      seg_q <= SEG_BLANK;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign busy = conv_busy;

endmodule

// File: tb/tb_cnt_seg_disp.sv
// Scoreboard bench for cnt_seg_disp: conversions are queued by the stimulus
// and checked by a monitor on each busy falling edge; scan slots are captured.
module tb_cnt_seg_disp;

  localparam int SCAN_DIV = 4;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic [7:0] count = 8'd0;
  logic [2:0] mode  = 3'd0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  logic mon_busy_prev = 1'b0;
  int   mon_val;

  always #5 clk = ~clk;

  cnt_seg_disp #(.SCAN_DIV(SCAN_DIV), .SCAN_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .count (count),
    .mode  (mode),
    .an    (an),
    .seg   (seg),
    .dp    (dp),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] digit_seg(input int d);
    case (d)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [11:0] bcd_of(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  // Monitor: every completed conversion must match the oldest queued value.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_busy_prev = 1'b0;
      end else begin
        if (mon_busy_prev && !busy) begin
          if (exp_q.size() == 0) begin
            check("done_without_expect", exp_q.size(), 1);
          end else begin
            mon_val = exp_q.pop_front();
            check($sformatf("bcd_reg_%0d", mon_val), dut.disp_q, bcd_of(mon_val));
          end
        end
        mon_busy_prev = busy;
      end
    end
  end

  // Capture one full scan and compare all four slots.
  task automatic check_scan(input string tag, input int v, input logic [2:0] m);
    logic [27:0] segs;
    logic [3:0]  dps, seen, sel;
    logic [6:0]  e_seg[4];
    logic        e_dp3;
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    e_seg[0] = digit_seg(o);
    e_seg[1] = digit_seg(t);
    e_seg[2] = digit_seg(h);
`ifdef LEADING_ZERO_BLANK_EN
    if (h == 0) begin
      e_seg[2] = 7'h7F;
      if (t == 0) e_seg[1] = 7'h7F;
    end
`endif
    case (m)
      3'd0, 3'd4: e_seg[3] = 7'h21;
      3'd1, 3'd5: e_seg[3] = 7'h41;
      default:    e_seg[3] = 7'h3F;
    endcase
    e_dp3 = !(m == 3'd4 || m == 3'd5);
    seen = '0; segs = '0; dps = '0;
    repeat (2) @(posedge clk);
    for (int c = 0; c < 8 * SCAN_DIV && seen != 4'hF; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        sel = 4'b0001 << i;
        if (an == ~sel) begin
          segs[7*i +: 7] = seg;
          dps[i]         = dp;
          seen[i]        = 1'b1;
        end
      end
    end
    check({tag, "_slots"}, seen, 4'hF);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_seg%0d", tag, i), segs[7*i +: 7], e_seg[i]);
    check({tag, "_dp012"}, dps[2:0], 3'b111);
    check({tag, "_dp3"}, dps[3], e_dp3);
  endtask

  // Apply a new count and time the conversion (samples taken at negedges).
  task automatic run_conv(input int v, output int lat, output int busy_len);
    count = 8'(v);
    exp_q.push_back(v);
    lat = 0; busy_len = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (busy) busy_len++;
      if (busy_len > 0 && !busy) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [3:0] pat[4];
  logic [2:0] modes[5];
  int lat, blen, c_end;

  initial begin
    pat   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    modes = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd3};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // Scan order and dwell: each anode low for SCAN_DIV clocks
    for (int c = 0; c < 10 && an == 4'hF; c++) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < SCAN_DIV; j++) begin
        if (k != 0 || j != 0) @(negedge clk);
        check($sformatf("scan_an_k%0d_j%0d", k, j), an, pat[k % 4]);
      end
    end
    check("idle_after_reset", busy, 1'b0);
    check_scan("z000", 0, 3'd0);

    // 0 -> 255: busy exactly 10 clocks, display at +11
    @(negedge clk);
    run_conv(255, lat, blen);
    check("lat_255", lat, 11);
    check("busy_len_255", blen, 10);
    @(negedge clk);
    check_scan("d255", 255, 3'd0);

    // 100 then 42 while busy: both convert in order
    @(negedge clk);
    count = 8'd100;
    exp_q.push_back(100);
    repeat (3) @(negedge clk);
    count = 8'd42;
    exp_q.push_back(42);
    c_end = 0;
    for (int c = 4; c <= 40; c++) begin
      @(negedge clk);
      if (c > 12 && !busy) begin
        c_end = c;
        break;
      end
    end
    check("rechange_done_by_22", (c_end > 12 && c_end <= 22), 1'b1);
    @(negedge clk);
    check_scan("d042", 42, 3'd0);

    // Mode glyph sweep on digit 3
    foreach (modes[i]) begin
      mode = modes[i];
      check_scan($sformatf("mode%0d", modes[i]), 42, modes[i]);
    end
    mode = 3'd0;

    // Reset in the middle of a conversion
    @(negedge clk);
    count = 8'd200;
    exp_q.push_back(200);
    repeat (5) @(negedge clk);
    check("busy_mid_shift", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_an", an, 4'hF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_dp", dp, 1'b1);
    check("midrst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    blen = 0; lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy) blen++;
      if (blen > 0 && !busy) begin
        lat = c;
        break;
      end
    end
    check("rst_recover_within_12", (lat > 0 && lat <= 12), 1'b1);
    @(negedge clk);
    check_scan("d200", 200, 3'd0);

    // Full sweep against the arithmetic model
    for (int v = 0; v < 256; v++) begin
      run_conv(v, lat, blen);
      check($sformatf("sweep_lat_%0d", v), lat, 11);
      @(negedge clk);
      if (v == 7 || v == 10 || v == 99 || v == 100)
        check_scan($sformatf("sw%0d", v), v, 3'd0);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
